// File: rtl/btt_pkg.sv
// Shared types for the branch target table: FSM state, stored entry layout and
// a reference target calculation for the default widths.
package btt_pkg;

  localparam int BTT_OFFW = 10;
  localparam int BTT_PCW  = 10;

  typedef enum logic {IDLE, LOAD} btt_state_t;

  typedef struct packed {
    logic                abs_flag;
    logic [BTT_OFFW-1:0] offset;
  } btt_entry_t;

  typedef struct packed {
    logic [BTT_PCW-1:0] target;
    logic               fault;
  } btt_result_t;

  function automatic btt_result_t calc_target(input logic [BTT_PCW-1:0] pc,
                                              input btt_entry_t         e);
    logic [BTT_PCW+1:0] sum;
    btt_result_t        r;
    sum = {2'b00, pc} + {{2{e.offset[BTT_OFFW-1]}}, e.offset};
    if (e.abs_flag) begin
      r.target = e.offset;
      r.fault  = 1'b0;
    end else begin
      r.target = sum[BTT_PCW-1:0];
      r.fault  = sum[BTT_PCW+1] | sum[BTT_PCW];
    end
    return r;
  endfunction

endpackage

// File: rtl/btt_target_calc.sv
// Combinational target resolution: relative (pc + signed offset, range checked)
// or absolute (offset resized to PC width, fault on lost upper bits).
module btt_target_calc #(
  parameter int OFFW = 10,
  parameter int PCW  = 10
) (
  input  logic [PCW-1:0]  pc,
  input  logic            abs_flag,
  input  logic [OFFW-1:0] offset,
  output logic [PCW-1:0]  target,
  output logic            fault
);

  // Wide enough that the true sum never overflows, so sign and upper bits are exact.
  localparam int SW = ((OFFW > PCW) ? OFFW : PCW) + 2;

  logic [SW-1:0] pc_ext;
  logic [SW-1:0] off_sext;
  logic [SW-1:0] off_zext;
  logic [SW-1:0] sum;
  logic          rel_fault;
  logic          abs_fault;

  assign pc_ext    = SW'(pc);
  assign off_sext  = SW'($signed(offset));
  assign off_zext  = SW'(offset);
  assign sum       = pc_ext + off_sext;
  assign rel_fault = sum[SW-1] | (|sum[SW-2:PCW]);
  assign abs_fault = |off_zext[SW-1:PCW];

  always_comb begin
    target = sum[PCW-1:0];
    fault  = rel_fault;
    if (abs_flag) begin
      target = off_zext[PCW-1:0];
      fault  = abs_fault;
    end
  end

endmodule

// File: rtl/branch_target_table.sv
// Programmable branch target table: bulk-load FSM, run-time patching and a
// 1-cycle registered lookup. Define BTT_PARITY_EN for per-entry parity + inj_par_err.
module branch_target_table
  import btt_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH),
  parameter int OFFW  = BTT_OFFW,
  parameter int PCW   = BTT_PCW
) (
  input  logic            Clk,
  input  logic            Reset_n,
`ifdef BTT_PARITY_EN
  input  logic            inj_par_err,
`endif
  input  logic            load_start,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [OFFW:0]   ld_data,
  output logic            load_busy,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [OFFW:0]   wr_data,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [AW-1:0]   req_addr,
  input  logic [PCW-1:0]  req_pc,
  output logic            resp_valid,
  output logic [PCW-1:0]  resp_target,
  output logic            resp_hit,
  output logic            resp_fault
);

  btt_state_t     state;
  logic [AW-1:0]  cnt;
  logic           up;
  logic [OFFW:0]  ent [DEPTH];
  logic [DEPTH-1:0] vld;

  logic           ld_fire, wr_fire, req_fire, w_en, fwd, rd_hit, par_err;
  logic [AW-1:0]  w_addr;
  logic [OFFW:0]  w_data, rd_data;
  logic [PCW-1:0] fall, calc_target_w, nxt_target;
  logic           calc_fault_w, nxt_fault;

  // req_ready stays low until the first clock after reset release.
  assign ld_ready  = (state == LOAD);
  assign load_busy = (state == LOAD);
  assign req_ready = up && (state == IDLE);

  assign ld_fire  = ld_valid && ld_ready;
  assign wr_fire  = wr_en && (state == IDLE);
  assign req_fire = req_valid && req_ready;
  assign w_en     = ld_fire || wr_fire;
  assign w_addr   = ld_fire ? cnt : wr_addr;
  assign w_data   = ld_fire ? ld_data : wr_data;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      up    <= 1'b0;
    end else begin
      up <= 1'b1;
      case (state)
        IDLE: if (load_start) begin
          state <= LOAD;
          cnt   <= '0;
        end
        LOAD: if (ld_fire) begin
          cnt <= cnt + 1'b1;
          if (cnt == AW'(DEPTH - 1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      vld <= '0;
    end else if (w_en) begin
      ent[w_addr] <= w_data;
      vld[w_addr] <= 1'b1;
    end
  end

  // A patch landing on the looked-up index this cycle is visible to that lookup.
  assign fwd     = wr_fire && (wr_addr == req_addr);
  assign rd_data = fwd ? wr_data : ent[req_addr];
  assign rd_hit  = fwd || vld[req_addr];

`ifdef BTT_PARITY_EN
  logic [DEPTH-1:0] par;
  logic             w_par, rd_par;

  assign w_par = (^w_data) ^ inj_par_err;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) par <= '0;
    else if (w_en) par[w_addr] <= w_par;
  end

  assign rd_par  = fwd ? w_par : par[req_addr];
  assign par_err = rd_hit && (rd_par != (^rd_data));
`else
  assign par_err = 1'b0;
`endif

  btt_target_calc #(.OFFW(OFFW), .PCW(PCW)) u_calc (
    .pc       (req_pc),
    .abs_flag (rd_data[OFFW]),
    .offset   (rd_data[OFFW-1:0]),
    .target   (calc_target_w),
    .fault    (calc_fault_w)
  );

  assign fall       = req_pc + PCW'(1);
  assign nxt_target = (!rd_hit || par_err) ? fall : calc_target_w;
  assign nxt_fault  = rd_hit && (par_err || calc_fault_w);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      resp_valid  <= 1'b0;
      resp_target <= '0;
      resp_hit    <= 1'b0;
      resp_fault  <= 1'b0;
    end else begin
      resp_valid <= req_fire;
      if (req_fire) begin
        resp_target <= nxt_target;
        resp_hit    <= rd_hit;
        resp_fault  <= nxt_fault;
      end
    end
  end

endmodule

// File: tb/tb_branch_target_table.sv
// Scoreboard bench for branch_target_table: directed lookups, bulk load,
// patch forwarding, wrap/fault boundaries and reset mid-load.
module tb_branch_target_table;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int OFFW  = 10;
  localparam int PCW   = 10;

  logic            Clk = 1'b0;
  logic            Reset_n;
`ifdef BTT_PARITY_EN
  logic            inj_par_err;
`endif
  logic            load_start, ld_valid, ld_ready, load_busy;
  logic [OFFW:0]   ld_data;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [OFFW:0]   wr_data;
  logic            req_valid, req_ready;
  logic [AW-1:0]   req_addr;
  logic [PCW-1:0]  req_pc;
  logic            resp_valid, resp_hit, resp_fault;
  logic [PCW-1:0]  resp_target;

  always #5 Clk = ~Clk;

  branch_target_table dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
`ifdef BTT_PARITY_EN
    .inj_par_err (inj_par_err),
`endif
    .load_start  (load_start),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_data     (ld_data),
    .load_busy   (load_busy),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_pc      (req_pc),
    .resp_valid  (resp_valid),
    .resp_target (resp_target),
    .resp_hit    (resp_hit),
    .resp_fault  (resp_fault)
  );

  typedef struct {
    int             cyc;
    logic [PCW-1:0] t;
    logic           h;
    logic           f;
    string          tag;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every response pops the oldest expectation, including its due cycle.
  always @(negedge Clk) begin
    if (resp_valid === 1'b1) begin
      exp_t e;
      if (sbq.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk({e.tag, "_cycle"},  cyc, e.cyc);
        chk({e.tag, "_target"}, 32'(resp_target), 32'(e.t));
        chk({e.tag, "_hit"},    32'(resp_hit), 32'(e.h));
        chk({e.tag, "_fault"},  32'(resp_fault), 32'(e.f));
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic issue(input string tag, input int a, input int pc, input int t,
                       input bit h, input bit f);
    exp_t e;
    req_valid = 1'b1;
    req_addr  = a[AW-1:0];
    req_pc    = pc[PCW-1:0];
    e.cyc = cyc + 1;
    e.t   = t[PCW-1:0];
    e.h   = h;
    e.f   = f;
    e.tag = tag;
    sbq.push_back(e);
    @(negedge Clk);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    tick();
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ld_ready"},    32'(ld_ready), 32'd0);
    chk({tag, "_load_busy"},   32'(load_busy), 32'd0);
    chk({tag, "_req_ready"},   32'(req_ready), 32'd0);
    chk({tag, "_resp_valid"},  32'(resp_valid), 32'd0);
    chk({tag, "_resp_target"}, 32'(resp_target), 32'd0);
    chk({tag, "_resp_hit"},    32'(resp_hit), 32'd0);
    chk({tag, "_resp_fault"},  32'(resp_fault), 32'd0);
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 20 && req_ready !== 1'b1; i++) tick();
    chk({tag, "_ready_timeout"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  logic [OFFW:0] words [DEPTH];

  initial begin
    Reset_n = 1'b0;
`ifdef BTT_PARITY_EN
    inj_par_err = 1'b0;
`endif
    load_start = 1'b0; ld_valid = 1'b0; ld_data = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    req_valid = 1'b0; req_addr = '0; req_pc = '0;

    #1;
    chk_outputs_zero("reset");
    tick(); tick();
    Reset_n = 1'b1;
    wait_ready("post_reset");

    // Empty table falls through to pc+1.
    issue("miss3", 3, 100, 101, 0, 0);
    req_valid = 1'b0;

    // Bulk load: entry0 = rel +276, entry1 = rel -278 (746 as 10-bit), rest rel i*3.
    words[0] = 11'd276;
    words[1] = 11'd746;
    for (int i = 2; i < DEPTH; i++) words[i] = 11'(i * 3);

    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ld_valid = 1'b0;
      @(negedge Clk);
      chk("load_gap_busy", 32'(load_busy), 32'd1);
      chk("load_gap_req_ready", 32'(req_ready), 32'd0);
      tick();
      ld_valid = 1'b1;
      ld_data  = words[i];
      if (i == 8) load_start = 1'b1;
      if (i == 10) begin
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 11'd500;
      end
      @(negedge Clk);
      chk("load_xfer_busy", 32'(load_busy), 32'd1);
      chk("load_xfer_ld_ready", 32'(ld_ready), 32'd1);
      chk("load_xfer_req_ready", 32'(req_ready), 32'd0);
      tick();
      load_start = 1'b0;
      wr_en = 1'b0;
    end
    ld_valid = 1'b0;
    @(negedge Clk);
    chk("load_done_busy", 32'(load_busy), 32'd0);
    chk("load_done_req_ready", 32'(req_ready), 32'd1);
    tick();

    issue("rel0", 0, 200, 476, 1, 0);
    issue("rel1_wrap", 1, 200, 946, 1, 1);
    issue("rel2_patch_ignored", 2, 100, 106, 1, 0);
    issue("rel7", 7, 1000, 1021, 1, 0);
    issue("rel15_over", 15, 1000, 21, 1, 1);
    req_valid = 1'b0;
    tick();

    // Patch idx12 = rel -22 in the same cycle as its lookup.
    wr_en = 1'b1; wr_addr = 4'd12; wr_data = 11'd1002;
    issue("fwd12", 12, 50, 28, 1, 0);
    wr_en = 1'b0;
    req_valid = 1'b0;

    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 11'd1115;
    tick();
    wr_en = 1'b0;
    issue("abs5", 5, 700, 91, 1, 0);
    issue("b2b_5", 5, 700, 91, 1, 0);
    issue("b2b_12", 12, 50, 28, 1, 0);
    issue("b2b_5b", 5, 3, 91, 1, 0);
    issue("rel12_under", 12, 10, 1012, 1, 1);
    req_valid = 1'b0;
    tick();

    // Reset during a bulk load after 7 words.
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    ld_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      ld_data = 11'(i + 100);
      tick();
    end
    ld_valid = 1'b0;
    Reset_n = 1'b0;
    #2;
    chk_outputs_zero("midload_reset");
    tick(); tick();
    Reset_n = 1'b1;
    wait_ready("midload_release");
    issue("after_reset2", 2, 5, 6, 0, 0);
    issue("after_reset0", 0, 1023, 0, 0, 0);
    req_valid = 1'b0;
    tick();

`ifdef BTT_PARITY_EN
    inj_par_err = 1'b1;
    wr_en = 1'b1; wr_addr = 4'd4; wr_data = 11'd5;
    tick();
    inj_par_err = 1'b0;
    wr_en = 1'b0;
    issue("par4_bad", 4, 10, 11, 1, 1);
    req_valid = 1'b0;
    wr_en = 1'b1; wr_addr = 4'd4; wr_data = 11'd5;
    tick();
    wr_en = 1'b0;
    issue("par4_good", 4, 10, 15, 1, 0);
    req_valid = 1'b0;
    tick();
`endif

    repeat (3) tick();
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_target_table.md
Name: branch_target_table

Overview:
- Programmable, parametrised branch-target table; successor to the fixed 16-entry combinational offset lookup.
- Sits between decode and the PC unit. A narrow instruction field indexes an entry; the block returns a resolved target PC one cycle later.
- Entries are loaded at boot by a streaming load FSM or patched individually at run time. Each entry is relative (PC + signed offset) or absolute.

Parameters:
- DEPTH, 16, number of entries (power of 2, 2..256)
- AW, $clog2(DEPTH), index width (derived; do not override)
- OFFW, 10, stored offset width, two's complement
- PCW, 10, program-counter width

Ports:
- Clk  in  1  clock, all state on rising edge
- Reset_n  in  1  asynchronous active-low reset
- load_start  in  1  pulse; begin bulk load of all DEPTH entries
- ld_valid  in  1  load-stream word valid
- ld_ready  out  1  block accepts load word
- ld_data  in  OFFW+1  {abs_flag, offset}
- load_busy  out  1  bulk load in progress
- wr_en  in  1  single-entry patch write
- wr_addr  in  AW  patch index
- wr_data  in  OFFW+1  {abs_flag, offset}
- req_valid  in  1  lookup request
- req_ready  out  1  lookup accepted this cycle
- req_addr  in  AW  entry index
- req_pc  in  PCW  PC of the branch
- resp_valid  out  1  response valid (one-cycle pulse per accepted request)
- resp_target  out  PCW  resolved target
- resp_hit  out  1  entry has been written since reset
- resp_fault  out  1  target out of range (see arithmetic)

Behaviour:
- Reset (async, Reset_n=0): all entries cleared, all entry-valid bits 0, FSM to IDLE.
  - Output reset values: ld_ready=0, load_busy=0, req_ready=0, resp_valid=0, resp_target=0, resp_hit=0, resp_fault=0.
  - Reset asserted mid-load abandons the load; the table is empty afterwards.
- FSM states:
  - IDLE: req_ready=1, ld_ready=0.
  - LOAD: req_ready=0, ld_ready=1, load_busy=1, load counter cnt starts at 0.
- FSM transitions:
  - IDLE->LOAD on load_start.
  - In LOAD, each cycle with ld_valid&&ld_ready writes entry[cnt], sets valid[cnt], and increments cnt.
  - LOAD->IDLE on the transfer where cnt==DEPTH-1.
  - load_start while in LOAD is ignored.
- Patch write: wr_en is honoured only in IDLE and ignored in LOAD. It writes entry[wr_addr] and sets valid[wr_addr].
- Lookup handshake: accepted when req_valid&&req_ready. Latency 1: resp_* are registered and resp_valid pulses exactly the next cycle.
  - Back-to-back requests give back-to-back responses.
  - With no accepted request, resp_valid=0 and the other resp_* hold their last values.
- Write/read collision: a patch to the same index in the same cycle as an accepted request is forwarded. The response uses the new wr_data, and resp_hit=1.
- Unwritten entry: resp_hit=0, resp_target=req_pc+1 (fall-through), resp_fault=0.
- Arithmetic, relative entry (abs_flag=0):
  - sum = {1'b0, req_pc} + sign_ext(offset) to PCW+2 bits, signed.
  - resp_fault=1 if sum<0 or sum>2^PCW-1.
  - resp_target=sum[PCW-1:0] regardless of fault (wrap-around).
- Arithmetic, absolute entry (abs_flag=1):
  - resp_target=offset zero-extended or truncated to PCW.
  - resp_fault=1 if OFFW>PCW and the truncated bits are nonzero.
- Simultaneous load_start and req_valid in IDLE: the request is accepted (req_ready is still 1 that cycle) and the FSM enters LOAD the next cycle.

Optional Feature:
- Macro: BTT_PARITY_EN.
- Defined:
  - Each entry stores an even-parity bit, computed at write (load or patch).
  - A lookup recomputes parity. On mismatch of a written entry, resp_fault=1 and resp_target=req_pc+1.
  - Adds input port inj_par_err (1 bit). When high during a write, it stores inverted parity (test hook).
- Undefined: no parity storage, no inj_par_err port, fault is from arithmetic only.

Decomposition:
- Package btt_pkg:
  - typedef enum logic {IDLE, LOAD} btt_state_t
  - entry struct {abs_flag, offset}
  - function calc_target(pc, entry) returning {target, fault}
- One sub-module is natural: btt_target_calc, the combinational adder/range check, reused by the PC unit.
- Storage, FSM and forwarding stay in the top module.

Test Plan:
- Reset then lookup idx 3, pc=100: resp_valid the next cycle, resp_hit=0, target=101, fault=0.
- Bulk load 16 words, with entry 0 = rel +276 and entry 1 = rel -278, ld_valid toggling every other cycle:
  - load_busy is high for the whole stream and req_ready=0 throughout.
  - idx0 with pc=200 gives target=476, fault=0.
  - idx1 with pc=200 gives target=946 (wrap), fault=1.
- Patch idx 12 = rel -22 in the same cycle as a request for idx 12, pc=50: response target=28, hit=1 (forwarding).
- Absolute entry idx 5 = abs 91, pc=700: target=91, fault=0. Then back-to-back requests on idx 5, 12, 5 give three consecutive resp_valid pulses with the correct targets.
- Reset_n asserted after 7 load words: all outputs 0; after release, a lookup of idx 2 gives hit=0.
- Parity (BTT_PARITY_EN defined): patch idx 4 with inj_par_err=1, then look up pc=10: fault=1, target=11.
